// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the MIPS pipeline hazard controller.
package hazard_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // EX operand source select
  localparam logic [1:0] FWD_RF = 2'd0;  // value read from the register file
  localparam logic [1:0] FWD_XM = 2'd1;  // result held in EX/MEM
  localparam logic [1:0] FWD_MW = 2'd2;  // result held in MEM/WB

  // Controller state
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // True when the instruction reads IR[20:16] as a source register.
  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       xm_regwrite,
  input  logic [4:0] xm_rd,
  input  logic       mw_regwrite,
  input  logic [4:0] mw_rd,
  output logic [1:0] sel
);

  // Youngest producer wins; $0 is hard-wired and never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (src != 5'd0 && xm_regwrite && xm_rd == src) begin
      sel = FWD_XM;
    end else if (src != 5'd0 && mw_regwrite && mw_rd == src) begin
      sel = FWD_MW;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Handshake-free block: all control outputs are same-cycle (Mealy) decisions
// from the current state and the stage inputs; the datapath samples them on
// the next rising clk edge.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             dx_memread,
  input  logic             dx_regwrite,
  input  logic [4:0]       dx_rd,
  input  logic [4:0]       dx_rs,
  input  logic [4:0]       dx_rt,
  input  logic             xm_regwrite,
  input  logic [4:0]       xm_rd,
  input  logic             mw_regwrite,
  input  logic [4:0]       mw_rd,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             xm_we,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout,
  output state_t           state_dbg
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              stall_evt;
  logic              flush_evt;
  logic [1:0]        fwd_a_raw;
  logic [1:0]        fwd_b_raw;

  assign state_dbg = state;

  // A lw is the only producer whose data is late; it always writes the RF.
  assign load_use = dx_memread && dx_regwrite && (dx_rd != 5'd0) &&
                    ((dx_rd == id_rs) || (uses_rt(id_op) && (dx_rd == id_rt)));

  fwd_unit u_fwd_a (
    .src         (dx_rs),
    .xm_regwrite (xm_regwrite),
    .xm_rd       (xm_rd),
    .mw_regwrite (mw_regwrite),
    .mw_rd       (mw_rd),
    .sel         (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src         (dx_rt),
    .xm_regwrite (xm_regwrite),
    .xm_rd       (xm_rd),
    .mw_regwrite (mw_regwrite),
    .mw_rd       (mw_rd),
    .sel         (fwd_b_raw)
  );

  // While reset is held the pipe runs free with register-file operands.
  assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

  // Next state and control outputs; priority busy > redirect > load-use.
  always_comb begin
    state_next = state;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    xm_we      = 1'b1;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    if (!rst_n) begin
      state_next = ST_RUN;
    end else if (dmem_busy) begin
      // Freeze everything; pending redirect/load-use is re-seen afterwards.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      xm_we      = 1'b0;
      state_next = ST_MEM_WAIT;
    end else if (ex_redirect) begin
      // Squash IF and ID, including any ID instruction that would stall.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
      state_next = ST_RUN;
    end else if (load_use && state != ST_LU_STALL) begin
      // Hold PC and IF/ID, inject one bubble into EX.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      stall_evt  = 1'b1;
      state_next = ST_LU_STALL;
    end else begin
      state_next = ST_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Memory-wait length tracking and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (dmem_busy) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= WAIT_MAX - 1'b1) begin
        err_timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating performance counters, bumped only when the action is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_evt && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus sequences.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;

  // {pc_we, ifid_we, ifid_flush, idex_flush, xm_we}
  localparam logic [4:0] C_NORM  = 5'b11001;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_FROZE = 5'b00000;

  logic             clk, rst_n;
  logic [5:0]       id_op;
  logic [4:0]       id_rs, id_rt;
  logic             dx_memread, dx_regwrite;
  logic [4:0]       dx_rd, dx_rs, dx_rt;
  logic             xm_regwrite, mw_regwrite;
  logic [4:0]       xm_rd, mw_rd;
  logic             ex_redirect, dmem_busy;
  logic             pc_we, ifid_we, ifid_flush, idex_flush, xm_we;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             err_timeout;
  state_t           state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       memread;
    logic [4:0] dx_rd, dx_rs, dx_rt;
    logic       xm_rw;
    logic [4:0] xm_rd;
    logic       mw_rw;
    logic [4:0] mw_rd;
    logic       redirect;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[16];

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .dx_memread  (dx_memread),
    .dx_regwrite (dx_regwrite),
    .dx_rd       (dx_rd),
    .dx_rs       (dx_rs),
    .dx_rt       (dx_rt),
    .xm_regwrite (xm_regwrite),
    .xm_rd       (xm_rd),
    .mw_regwrite (mw_regwrite),
    .mw_rd       (mw_rd),
    .ex_redirect (ex_redirect),
    .dmem_busy   (dmem_busy),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .xm_we       (xm_we),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic clear_inputs();
    id_op = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
    dx_memread = 1'b0; dx_regwrite = 1'b0; dx_rd = 5'd0; dx_rs = 5'd0; dx_rt = 5'd0;
    xm_regwrite = 1'b0; xm_rd = 5'd0; mw_regwrite = 1'b0; mw_rd = 5'd0;
    ex_redirect = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    id_op = v.op; id_rs = v.rs; id_rt = v.rt;
    dx_memread = v.memread; dx_regwrite = v.memread; dx_rd = v.dx_rd;
    dx_rs = v.dx_rs; dx_rt = v.dx_rt;
    xm_regwrite = v.xm_rw; xm_rd = v.xm_rd;
    mw_regwrite = v.mw_rw; mw_rd = v.mw_rd;
    ex_redirect = v.redirect; dmem_busy = 1'b0;
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic drive_load_use();
    clear_inputs();
    id_op = OP_RTYPE; id_rs = 5'd2; id_rt = 5'd4;
    dx_memread = 1'b1; dx_regwrite = 1'b1; dx_rd = 5'd2;
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic memread, input logic [4:0] drd, input logic [4:0] drs,
                              input logic [4:0] drt, input logic xrw, input logic [4:0] xrd,
                              input logic mrw, input logic [4:0] mrd, input logic redir,
                              input logic [8:0] exp);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.memread = memread;
    v.dx_rd = drd; v.dx_rs = drs; v.dx_rt = drt;
    v.xm_rw = xrw; v.xm_rd = xrd; v.mw_rw = mrw; v.mw_rd = mrd;
    v.redirect = redir; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] ctl();
    return {pc_we, ifid_we, ifid_flush, idex_flush, xm_we, fwd_a, fwd_b};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  initial begin
    // Vector table
    vecs[0]  = mk(OP_RTYPE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {C_NORM,  FWD_RF, FWD_RF});
    vecs[1]  = mk(OP_ADDI,  2, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_STALL, FWD_RF, FWD_RF});
    vecs[2]  = mk(OP_ADDI,  6, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_NORM,  FWD_RF, FWD_RF});
    vecs[3]  = mk(OP_SW,    7, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_STALL, FWD_RF, FWD_RF});
    vecs[4]  = mk(OP_BEQ,   9, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_STALL, FWD_RF, FWD_RF});
    vecs[5]  = mk(OP_BNE,   9, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_STALL, FWD_RF, FWD_RF});
    vecs[6]  = mk(OP_RTYPE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, {C_NORM,  FWD_RF, FWD_RF});
    vecs[7]  = mk(OP_RTYPE, 2, 4, 0, 2, 0, 0, 0, 0, 0, 0, 0, {C_NORM,  FWD_RF, FWD_RF});
    vecs[8]  = mk(OP_J,     3, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_NORM,  FWD_RF, FWD_RF});
    vecs[9]  = mk(OP_RTYPE, 9, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, {C_STALL, FWD_RF, FWD_RF});
    vecs[10] = mk(OP_RTYPE, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, {C_NORM,  FWD_XM, FWD_RF});
    vecs[11] = mk(OP_RTYPE, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, {C_NORM,  FWD_RF, FWD_RF});
    vecs[12] = mk(OP_RTYPE, 0, 0, 0, 0, 0, 7, 0, 7, 1, 7, 0, {C_NORM,  FWD_RF, FWD_MW});
    vecs[13] = mk(OP_RTYPE, 0, 0, 0, 0, 6, 5, 1, 5, 1, 6, 0, {C_NORM,  FWD_MW, FWD_XM});
    vecs[14] = mk(OP_RTYPE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {C_REDIR, FWD_RF, FWD_RF});
    vecs[15] = mk(OP_RTYPE, 2, 4, 1, 2, 0, 0, 0, 0, 0, 0, 1, {C_REDIR, FWD_RF, FWD_RF});
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);

    // Reset: outputs forced even with busy asserted
    clear_inputs();
    dmem_busy = 1'b1;
    xm_regwrite = 1'b1; xm_rd = 5'd3; dx_rs = 5'd3;
    rst_n = 1'b0;
    #3;
    check("reset_ctl", 16'(ctl()), 16'({C_NORM, FWD_RF, FWD_RF}));
    check("reset_cnt", 16'({stall_cnt, flush_cnt}), 16'd0);
    check("reset_state", 16'(state_dbg), 16'(ST_RUN));
    check("reset_err", 16'(err_timeout), 16'd0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    step();

    // Load-use stall, then one bubble with MW forwarding
    drive_load_use();
    @(negedge clk);
    check("lu_stall_ctl", 16'(ctl()), 16'({C_STALL, FWD_RF, FWD_RF}));
    step();
    check("lu_stall_cnt", 16'(stall_cnt), 16'd1);
    check("lu_state", 16'(state_dbg), 16'(ST_LU_STALL));
    mw_regwrite = 1'b1; mw_rd = 5'd2; dx_rs = 5'd2;
    @(negedge clk);
    check("lu_bubble_ctl", 16'(ctl()), 16'({C_NORM, FWD_MW, FWD_RF}));
    step();
    check("lu_back_run", 16'(state_dbg), 16'(ST_RUN));
    check("lu_cnt_once", 16'(stall_cnt), 16'd1);
    clear_inputs();
    step();

    // Table: each vector followed by an idle cycle
    for (int i = 0; i < 16; i++) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      drive_vec(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), 16'(ctl()), 16'(e));
      step();
      clear_inputs();
      step();
    end
    check("table_stall_cnt", 16'(stall_cnt), 16'd6);
    check("table_flush_cnt", 16'(flush_cnt), 16'd2);

    // Counter saturation
    for (int i = 0; i < 6; i++) begin
      ex_redirect = 1'b1;
      step();
    end
    clear_inputs();
    check("flush_sat", 16'(flush_cnt), 16'd7);
    for (int i = 0; i < 2; i++) begin
      drive_load_use();
      step();
      clear_inputs();
      step();
    end
    check("stall_sat", 16'(stall_cnt), 16'd7);

    // Async reset in the middle of LU_STALL
    drive_load_use();
    step();
    check("pre_rst_state", 16'(state_dbg), 16'(ST_LU_STALL));
    dmem_busy = 1'b1;
    xm_regwrite = 1'b1; xm_rd = 5'd3; dx_rs = 5'd3;
    #1;
    check("busy_ctl", 16'(ctl()), 16'({C_FROZE, FWD_XM, FWD_RF}));
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", 16'(ctl()), 16'({C_NORM, FWD_RF, FWD_RF}));
    check("async_rst_cnt", 16'({stall_cnt, flush_cnt}), 16'd0);
    check("async_rst_state", 16'(state_dbg), 16'(ST_RUN));
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    step();

    // Memory wait with a pending load-use, crossing the timeout
    drive_load_use();
    dmem_busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("busy%0d_ctl", k), 16'(ctl()), 16'({C_FROZE, FWD_RF, FWD_RF}));
      step();
      check($sformatf("busy%0d_err", k), 16'(err_timeout), 16'(k >= MEM_TIMEOUT));
      check($sformatf("busy%0d_state", k), 16'(state_dbg), 16'(ST_MEM_WAIT));
    end
    check("busy_no_stall", 16'(stall_cnt), 16'd0);
    dmem_busy = 1'b0;
    @(negedge clk);
    check("post_busy_ctl", 16'(ctl()), 16'({C_STALL, FWD_RF, FWD_RF}));
    step();
    check("post_busy_stall", 16'(stall_cnt), 16'd1);
    check("post_busy_flush", 16'(flush_cnt), 16'd0);
    check("post_busy_state", 16'(state_dbg), 16'(ST_LU_STALL));
    clear_inputs();
    step();
    check("err_sticky", 16'(err_timeout), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
